// File: rtl/siso_pkg.sv
// Shared types and defaults for the SISO block scheduler.
package siso_pkg;

  localparam int unsigned BLKLEN_W_DEF   = 13;
  localparam int unsigned MIN_BLKLEN_DEF = 40;
  localparam int unsigned MAX_BLKLEN_DEF = 6144;

  // Trellis termination steps appended when the tail is enabled.
  localparam int unsigned TAIL_LEN = 3;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFwd,
    StBwd,
    StDone
  } state_e;

endpackage

// File: rtl/siso_sched_if.sv
// Stream/config inputs and buffer-control outputs of the SISO block scheduler.
interface siso_sched_if import siso_pkg::*; #(
  parameter int unsigned BLKLEN_W = BLKLEN_W_DEF
);

  logic [15:0]         blklen;
  logic                valid_blklen;
  logic                valid_in;
  logic                valid_apriori;

  logic                wr_en;
  logic [BLKLEN_W-1:0] wr_addr;
  logic                apr_wr_en;
  logic [BLKLEN_W-1:0] apr_wr_addr;
  logic                rd_en;
  logic [BLKLEN_W-1:0] rd_addr;
  logic                alpha_init;
  logic                fwd_en;
  logic                beta_init;
  logic                bwd_en;
  logic                busy;
  logic                done;
  logic                cfg_err;
  logic                ovf_err;

  // Upstream source / observer side.
  modport master (
    output blklen, valid_blklen, valid_in, valid_apriori,
    input  wr_en, wr_addr, apr_wr_en, apr_wr_addr, rd_en, rd_addr,
    input  alpha_init, fwd_en, beta_init, bwd_en, busy, done, cfg_err, ovf_err
  );

  // Scheduler side.
  modport slave (
    input  blklen, valid_blklen, valid_in, valid_apriori,
    output wr_en, wr_addr, apr_wr_en, apr_wr_addr, rd_en, rd_addr,
    output alpha_init, fwd_en, beta_init, bwd_en, busy, done, cfg_err, ovf_err
  );

endinterface

// File: rtl/siso_step_cnt.sv
// Loadable up/down step counter with terminal-count compare.
// Priority: clear, then load, then count.
module siso_step_cnt import siso_pkg::*; #(
  parameter int unsigned BLKLEN_W = BLKLEN_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                load_i,
  input  logic [BLKLEN_W-1:0] load_val_i,
  input  logic                en_i,
  input  logic                up_i,
  input  logic [BLKLEN_W-1:0] term_i,
  output logic [BLKLEN_W-1:0] cnt_o,
  output logic                tc_o
);

  logic [BLKLEN_W-1:0] cnt_q, cnt_d;

  // Next count value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = up_i ? cnt_q + BLKLEN_W'(1) : cnt_q - BLKLEN_W'(1);
    end
  end

  // Count register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/siso_sched.sv
// SISO block scheduler: latches K, counts LLR pairs and a-priori words into the
// step buffer, then runs one ascending forward pass and one descending backward
// pass over it. All outputs are registered.
// Optional feature: define SISO_SCHED_TAIL_EN to load and replay 3 termination
// steps (addresses K..K+2) ahead of the backward pass.
module siso_sched import siso_pkg::*; #(
  parameter int unsigned BLKLEN_W   = BLKLEN_W_DEF,
  parameter int unsigned MIN_BLKLEN = MIN_BLKLEN_DEF,
  parameter int unsigned MAX_BLKLEN = MAX_BLKLEN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  siso_sched_if.slave bus
);

  state_e              state_q, state_d;
  logic [BLKLEN_W-1:0] blk_q, blk_d;
  logic                phase_q, phase_d;

  logic                wr_en_q, wr_en_d;
  logic [BLKLEN_W-1:0] wr_addr_q, wr_addr_d;
  logic                apr_wr_en_q, apr_wr_en_d;
  logic [BLKLEN_W-1:0] apr_wr_addr_q, apr_wr_addr_d;
  logic                rd_en_q, rd_en_d;
  logic                alpha_init_q, alpha_init_d;
  logic                fwd_en_q, fwd_en_d;
  logic                beta_init_q, beta_init_d;
  logic                bwd_en_q, bwd_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cfg_err_q, cfg_err_d;
  logic                ovf_err_q, ovf_err_d;

  logic                cnt_clr;
  logic                wr_inc, apr_inc;
  logic                rd_load, rd_inc, rd_up;
  logic [BLKLEN_W-1:0] rd_load_val, rd_term;
  logic [BLKLEN_W-1:0] wr_cnt, apr_cnt, rd_cnt;
  logic                wr_full, apr_full, rd_tc;
  logic [BLKLEN_W-1:0] n_steps;
  logic                cfg_ok;

`ifdef SISO_SCHED_TAIL_EN
  assign n_steps = blk_q + BLKLEN_W'(TAIL_LEN);
`else
  assign n_steps = blk_q;
`endif

  assign cfg_ok = (32'(bus.blklen) >= MIN_BLKLEN) && (32'(bus.blklen) <= MAX_BLKLEN);

  // Forward pass ends on K-1, backward pass ends on 0.
  assign rd_term = (state_q == StBwd) ? '0 : blk_q - BLKLEN_W'(1);

  siso_step_cnt #(.BLKLEN_W(BLKLEN_W)) u_wr_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (wr_inc),
    .up_i       (1'b1),
    .term_i     (n_steps),
    .cnt_o      (wr_cnt),
    .tc_o       (wr_full)
  );

  siso_step_cnt #(.BLKLEN_W(BLKLEN_W)) u_apr_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (apr_inc),
    .up_i       (1'b1),
    .term_i     (n_steps),
    .cnt_o      (apr_cnt),
    .tc_o       (apr_full)
  );

  // The read counter is the rd_addr output register itself.
  siso_step_cnt #(.BLKLEN_W(BLKLEN_W)) u_rd_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .load_i     (rd_load),
    .load_val_i (rd_load_val),
    .en_i       (rd_inc),
    .up_i       (rd_up),
    .term_i     (rd_term),
    .cnt_o      (rd_cnt),
    .tc_o       (rd_tc)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d       = state_q;
    blk_d         = blk_q;
    phase_d       = phase_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    apr_wr_en_d   = 1'b0;
    apr_wr_addr_d = apr_wr_addr_q;
    rd_en_d       = 1'b0;
    alpha_init_d  = 1'b0;
    fwd_en_d      = 1'b0;
    beta_init_d   = 1'b0;
    bwd_en_d      = 1'b0;
    done_d        = 1'b0;
    cfg_err_d     = 1'b0;
    ovf_err_d     = 1'b0;
    cnt_clr       = 1'b0;
    wr_inc        = 1'b0;
    apr_inc       = 1'b0;
    rd_load       = 1'b0;
    rd_load_val   = '0;
    rd_inc        = 1'b0;
    rd_up         = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (bus.valid_blklen) begin
          if (cfg_ok) begin
            blk_d   = bus.blklen[BLKLEN_W-1:0];
            phase_d = 1'b0;
            cnt_clr = 1'b1;
            state_d = StLoad;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
        if (bus.valid_in || bus.valid_apriori) ovf_err_d = 1'b1;
      end

      StLoad: begin
        if (bus.valid_blklen) cfg_err_d = 1'b1;
        if (bus.valid_in) begin
          if (wr_full) begin
            ovf_err_d = 1'b1;
          end else begin
            phase_d = ~phase_q;
            // Second word of the pair completes the step.
            if (phase_q) begin
              wr_en_d   = 1'b1;
              wr_addr_d = wr_cnt;
              wr_inc    = 1'b1;
            end
          end
        end
        if (bus.valid_apriori) begin
          if (apr_full) begin
            ovf_err_d = 1'b1;
          end else begin
            apr_wr_en_d   = 1'b1;
            apr_wr_addr_d = apr_cnt;
            apr_inc       = 1'b1;
          end
        end
        if (wr_full && apr_full) begin
          state_d      = StFwd;
          rd_load      = 1'b1;
          rd_load_val  = '0;
          rd_en_d      = 1'b1;
          fwd_en_d     = 1'b1;
          alpha_init_d = 1'b1;
        end
      end

      StFwd: begin
        if (bus.valid_blklen) cfg_err_d = 1'b1;
        if (bus.valid_in || bus.valid_apriori) ovf_err_d = 1'b1;
        rd_en_d = 1'b1;
        if (rd_tc) begin
          // Backward pass begins at the highest loaded step (tail included).
          state_d     = StBwd;
          rd_load     = 1'b1;
          rd_load_val = n_steps - BLKLEN_W'(1);
          bwd_en_d    = 1'b1;
          beta_init_d = 1'b1;
        end else begin
          fwd_en_d = 1'b1;
          rd_inc   = 1'b1;
        end
      end

      StBwd: begin
        if (bus.valid_blklen) cfg_err_d = 1'b1;
        if (bus.valid_in || bus.valid_apriori) ovf_err_d = 1'b1;
        if (rd_tc) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          rd_en_d  = 1'b1;
          bwd_en_d = 1'b1;
          rd_inc   = 1'b1;
          rd_up    = 1'b0;
        end
      end

      StDone: begin
        if (bus.valid_blklen) cfg_err_d = 1'b1;
        if (bus.valid_in || bus.valid_apriori) ovf_err_d = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      blk_q         <= '0;
      phase_q       <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      apr_wr_en_q   <= 1'b0;
      apr_wr_addr_q <= '0;
      rd_en_q       <= 1'b0;
      alpha_init_q  <= 1'b0;
      fwd_en_q      <= 1'b0;
      beta_init_q   <= 1'b0;
      bwd_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
      ovf_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      blk_q         <= blk_d;
      phase_q       <= phase_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      apr_wr_en_q   <= apr_wr_en_d;
      apr_wr_addr_q <= apr_wr_addr_d;
      rd_en_q       <= rd_en_d;
      alpha_init_q  <= alpha_init_d;
      fwd_en_q      <= fwd_en_d;
      beta_init_q   <= beta_init_d;
      bwd_en_q      <= bwd_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      cfg_err_q     <= cfg_err_d;
      ovf_err_q     <= ovf_err_d;
    end
  end

  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.apr_wr_en   = apr_wr_en_q;
  assign bus.apr_wr_addr = apr_wr_addr_q;
  assign bus.rd_en       = rd_en_q;
  assign bus.rd_addr     = rd_cnt;
  assign bus.alpha_init  = alpha_init_q;
  assign bus.fwd_en      = fwd_en_q;
  assign bus.beta_init   = beta_init_q;
  assign bus.bwd_en      = bwd_en_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_siso_sched.sv
// Directed bench for siso_sched; adapts step counts when SISO_SCHED_TAIL_EN is set.
module tb_siso_sched;

  localparam int unsigned W = 13;
`ifdef SISO_SCHED_TAIL_EN
  localparam int TAIL = 3;
`else
  localparam int TAIL = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  siso_sched_if #(.BLKLEN_W(W)) bus ();

  siso_sched #(
    .BLKLEN_W   (W),
    .MIN_BLKLEN (40),
    .MAX_BLKLEN (6144)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.blklen        = 16'd0;
    bus.valid_blklen  = 1'b0;
    bus.valid_in      = 1'b0;
    bus.valid_apriori = 1'b0;
  endtask

  // Stimulus only: configure K and stream the full block (a-priori alongside).
  task automatic load_block(input int k);
    int n;
    n = k + TAIL;
    bus.blklen       = 16'(k);
    bus.valid_blklen = 1'b1;
    tick();
    bus.valid_blklen = 1'b0;
    for (int i = 0; i < 2 * n; i++) begin
      bus.valid_in      = 1'b1;
      bus.valid_apriori = (i < n);
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    logic [10:0] flags;
    idle_inputs();
    rst = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    flags = {bus.wr_en, bus.apr_wr_en, bus.rd_en, bus.alpha_init, bus.fwd_en,
             bus.beta_init, bus.bwd_en, bus.busy, bus.done, bus.cfg_err, bus.ovf_err};
    n_cmp++;
    if (flags !== 11'd0) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 0", flags);
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    n_cmp++;
    if ({bus.wr_addr, bus.apr_wr_addr, bus.rd_addr} !== '0) begin
      n_err++;
      $display("FAIL reset_addrs: got %0d/%0d/%0d expected 0/0/0",
               bus.wr_addr, bus.apr_wr_addr, bus.rd_addr);
    end
  endtask

  // Full block with checks on every load write, every read and the done pulse.
  task automatic run_block(input int k, input string tag);
    int n;
    n = k + TAIL;
    bus.blklen       = 16'(k);
    bus.valid_blklen = 1'b1;
    tick();
    bus.valid_blklen = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.cfg_err !== 1'b0) begin
      n_err++;
      $display("FAIL %s_cfg_accept: got busy=%b cfg_err=%b expected 1/0", tag, bus.busy,
               bus.cfg_err);
    end
    for (int i = 0; i < 2 * n; i++) begin
      bus.valid_in      = 1'b1;
      bus.valid_apriori = (i < n);
      tick();
      n_cmp++;
      if (bus.wr_en !== i[0] || (i[0] && bus.wr_addr !== W'(i / 2))) begin
        n_err++;
        $display("FAIL %s_wr word %0d: got en=%b addr=%0d expected en=%b addr=%0d", tag, i,
                 bus.wr_en, bus.wr_addr, i[0], i / 2);
      end
      n_cmp++;
      if (bus.apr_wr_en !== (i < n) || (i < n && bus.apr_wr_addr !== W'(i))) begin
        n_err++;
        $display("FAIL %s_apr word %0d: got en=%b addr=%0d expected en=%b addr=%0d", tag, i,
                 bus.apr_wr_en, bus.apr_wr_addr, (i < n), i);
      end
      n_cmp++;
      if (bus.rd_en !== 1'b0 || bus.ovf_err !== 1'b0) begin
        n_err++;
        $display("FAIL %s_load_quiet word %0d: got rd_en=%b ovf=%b expected 0/0", tag, i,
                 bus.rd_en, bus.ovf_err);
      end
    end
    idle_inputs();
    tick();
    for (int j = 0; j < k; j++) begin
      n_cmp++;
      if (bus.rd_en !== 1'b1 || bus.fwd_en !== 1'b1 || bus.bwd_en !== 1'b0 ||
          bus.rd_addr !== W'(j) || bus.alpha_init !== (j == 0) || bus.beta_init !== 1'b0) begin
        n_err++;
        $display("FAIL %s_fwd step %0d: got rd=%b fwd=%b bwd=%b addr=%0d ai=%b bi=%b expected 1 1 0 %0d %b 0",
                 tag, j, bus.rd_en, bus.fwd_en, bus.bwd_en, bus.rd_addr, bus.alpha_init,
                 bus.beta_init, j, (j == 0));
      end
      tick();
    end
    for (int j = 0; j < n; j++) begin
      n_cmp++;
      if (bus.rd_en !== 1'b1 || bus.fwd_en !== 1'b0 || bus.bwd_en !== 1'b1 ||
          bus.rd_addr !== W'(n - 1 - j) || bus.beta_init !== (j == 0) ||
          bus.alpha_init !== 1'b0 || bus.done !== 1'b0) begin
        n_err++;
        $display("FAIL %s_bwd step %0d: got rd=%b fwd=%b bwd=%b addr=%0d bi=%b ai=%b done=%b expected 1 0 1 %0d %b 0 0",
                 tag, j, bus.rd_en, bus.fwd_en, bus.bwd_en, bus.rd_addr, bus.beta_init,
                 bus.alpha_init, bus.done, n - 1 - j, (j == 0));
      end
      tick();
    end
    n_cmp++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.rd_en !== 1'b0 || bus.bwd_en !== 1'b0) begin
      n_err++;
      $display("FAIL %s_done: got done=%b busy=%b rd=%b bwd=%b expected 1 1 0 0", tag, bus.done,
               bus.busy, bus.rd_en, bus.bwd_en);
    end
    tick();
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_idle_after: got done=%b busy=%b expected 0 0", tag, bus.done, bus.busy);
    end
  endtask

  task automatic test_k512();
    run_block(512, "k512");
  endtask

  task automatic test_tail();
    run_block(40, "k40");
  endtask

  task automatic test_cfg_err();
    int bad [2] = '{39, 6145};
    foreach (bad[b]) begin
      bus.blklen       = 16'(bad[b]);
      bus.valid_blklen = 1'b1;
      tick();
      bus.valid_blklen = 1'b0;
      n_cmp++;
      if (bus.cfg_err !== 1'b1 || bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL cfg_reject %0d: got cfg_err=%b busy=%b expected 1 0", bad[b],
                 bus.cfg_err, bus.busy);
      end
      tick();
      n_cmp++;
      if (bus.cfg_err !== 1'b0 || bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL cfg_pulse %0d: got cfg_err=%b busy=%b expected 0 0", bad[b],
                 bus.cfg_err, bus.busy);
      end
    end
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    n_cmp++;
    if (bus.ovf_err !== 1'b1 || bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_word: got ovf=%b wr_en=%b busy=%b expected 1 0 0", bus.ovf_err,
               bus.wr_en, bus.busy);
    end
    bus.blklen       = 16'd40;
    bus.valid_blklen = 1'b1;
    tick();
    bus.valid_blklen = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.cfg_err !== 1'b0 || bus.ovf_err !== 1'b0) begin
      n_err++;
      $display("FAIL cfg_min_accept: got busy=%b cfg_err=%b ovf=%b expected 1 0 0", bus.busy,
               bus.cfg_err, bus.ovf_err);
    end
  endtask

  // Continues the K=40 block left in LOAD by test_cfg_err.
  task automatic test_ovf();
    int n, wr_pulses, ovf_pulses, exp_addr, last_addr;
    bit seen_done;
    n          = 40 + TAIL;
    wr_pulses  = 0;
    ovf_pulses = 0;
    exp_addr   = 0;
    last_addr  = -1;
    for (int i = 0; i < n; i++) begin
      bus.valid_apriori = 1'b1;
      tick();
    end
    bus.valid_apriori = 1'b0;
    for (int i = 0; i < 2 * n + 2 + 5; i++) begin
      bus.valid_in = (i < 2 * n + 2);
      tick();
      if (bus.ovf_err === 1'b1) ovf_pulses++;
      if (bus.wr_en === 1'b1) begin
        wr_pulses++;
        n_cmp++;
        if (bus.wr_addr !== W'(exp_addr)) begin
          n_err++;
          $display("FAIL ovf_wr_addr: got %0d expected %0d", bus.wr_addr, exp_addr);
        end
        last_addr = int'(bus.wr_addr);
        exp_addr++;
      end
    end
    bus.valid_in = 1'b0;
    n_cmp++;
    if (ovf_pulses != 2) begin
      n_err++;
      $display("FAIL ovf_count: got %0d expected 2", ovf_pulses);
    end
    n_cmp++;
    if (wr_pulses != n || last_addr != n - 1) begin
      n_err++;
      $display("FAIL ovf_writes: got %0d pulses last %0d expected %0d pulses last %0d",
               wr_pulses, last_addr, n, n - 1);
    end
    seen_done = 1'b0;
    for (int c = 0; c < 400 && !seen_done; c++) begin
      if (bus.done === 1'b1) seen_done = 1'b1;
      else tick();
    end
    n_cmp++;
    if (!seen_done) begin
      n_err++;
      $display("FAIL ovf_block_done: got no done within 400 cycles expected done");
    end
    tick();
  endtask

  task automatic test_midfwd_reset();
    load_block(128);
    tick();
    repeat (100) tick();
    n_cmp++;
    if (bus.rd_addr !== W'(100) || bus.fwd_en !== 1'b1) begin
      n_err++;
      $display("FAIL midfwd_pos: got addr=%0d fwd=%b expected 100 1", bus.rd_addr, bus.fwd_en);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_cmp++;
    if (bus.rd_en !== 1'b0 || bus.busy !== 1'b0 || bus.fwd_en !== 1'b0 ||
        bus.rd_addr !== '0) begin
      n_err++;
      $display("FAIL midfwd_reset: got rd=%b busy=%b fwd=%b addr=%0d expected 0 0 0 0",
               bus.rd_en, bus.busy, bus.fwd_en, bus.rd_addr);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    run_block(64, "k64");
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_k512();
    test_tail();
    test_cfg_err();
    test_ovf();
    test_midfwd_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/siso_sched.md
# siso_sched

Block-level scheduler for the SISO decoder datapath. It latches the block length and counts incoming LLR word pairs and a-priori words into the step buffer. It then sequences one forward (alpha) pass and one backward (beta/LLR) pass over the buffer by driving read addresses and phase strobes. It sits between the stream input of `top` and the branch/state-metric units, and owns all buffer addressing.

## Interface
- `BLKLEN_W`, 13: width of step addresses and counters.
- `MIN_BLKLEN`, 40: smallest accepted block length K.
- `MAX_BLKLEN`, 6144: largest accepted K. Must satisfy MAX_BLKLEN+3 < 2^BLKLEN_W.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low. `rst`=0 at a rising edge resets the block.
- `blklen` in 16: block length K, sampled when `valid_blklen`=1.
- `valid_blklen` in 1: config strobe.
- `valid_in` in 1: one 16-bit input word per strobe. Words alternate systematic, then parity; two words form one trellis step.
- `valid_apriori` in 1: one a-priori word per strobe.
- `wr_en` out 1: step-buffer write, pulses when a word pair completes.
- `wr_addr` out BLKLEN_W: step index for `wr_en`.
- `apr_wr_en` out 1: a-priori buffer write. Mirrors `valid_apriori` during LOAD.
- `apr_wr_addr` out BLKLEN_W: a-priori step index.
- `rd_en` out 1: buffer read strobe.
- `rd_addr` out BLKLEN_W: read step index.
- `alpha_init` out 1: forward metric initialisation. Coincident with the first FWD read.
- `fwd_en` out 1: forward recursion active.
- `beta_init` out 1: backward metric initialisation. Coincident with the first BWD read.
- `bwd_en` out 1: backward recursion and LLR output active.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse at block end.
- `cfg_err` out 1: one-cycle pulse when a config is rejected.
- `ovf_err` out 1: one-cycle pulse when a word arrives outside LOAD or beyond the block.

## Operation
- States are IDLE, LOAD, FWD, BWD, DONE.
- **IDLE:**
  - `valid_blklen` with MIN_BLKLEN ≤ `blklen` ≤ MAX_BLKLEN latches K and moves to LOAD. All counters are cleared.
  - An out-of-range `blklen` gives a `cfg_err` pulse and the block stays in IDLE.
  - `valid_in` or `valid_apriori` in IDLE gives an `ovf_err` pulse and the word is dropped.
- **LOAD:**
  - A phase bit toggles on each `valid_in`. On the second word of a pair, `wr_en`=1 with `wr_addr` = pair count, then pair count increments.
  - Each `valid_apriori` gives `apr_wr_en` at `apr_wr_addr` = a-priori count, then that count increments.
  - Words beyond N steps on either stream are dropped with `ovf_err`. N is defined under Configuration.
  - `valid_in` and `valid_apriori` in the same cycle are both accepted.
  - When both counts reach N, the state moves to FWD on the next edge.
- **FWD:**
  - `rd_addr` runs 0 to K-1 ascending, one step per cycle, with `rd_en`=`fwd_en`=1.
  - `alpha_init`=1 only with address 0.
- **BWD:**
  - Starts the cycle after the last FWD read, with no bubble.
  - `rd_addr` descends to 0, with `rd_en`=`bwd_en`=1.
  - `beta_init`=1 only on the first BWD read.
- **DONE:** `done`=1 for one cycle, then IDLE.
- `valid_blklen` while `busy` gives a `cfg_err` pulse and is ignored.
- `rst`=0 in any state returns to IDLE and clears counters, phase bit and K. All outputs are 0 from the next edge.

## Timing
- Reset values: every output is 0.
- All outputs are registered.
- `wr_en` and `apr_wr_en` follow their input strobe by 1 cycle.
- First FWD read: 1 cycle after the edge on which the last LOAD write is registered.
- FWD lasts K cycles.
- BWD lasts K cycles, or K+3 with the tail enabled.
- `done` comes 1 cycle after the last BWD read.
- `busy` falls in the same cycle that `done` falls.
- Total processing time after LOAD is 2K+1 cycles (2K+4 with the tail), plus 1.
- No backpressure exists. The upstream source must not exceed one `valid_in` per cycle.

## Configuration
- `SISO_SCHED_TAIL_EN` defined:
  - N = K+3. LOAD expects 3 extra termination steps at addresses K..K+2.
  - BWD starts at `rd_addr`=K+2, descends through the tail with `beta_init` on K+2, then continues K-1 down to 0.
  - `bwd_en` is high for K+3 cycles.
- `SISO_SCHED_TAIL_EN` undefined:
  - N = K.
  - BWD starts at K-1 with `beta_init` there.
  - Tail addresses are never generated.

## Structure
- Package `siso_pkg`: the state enum, MIN_BLKLEN/MAX_BLKLEN defaults, and TAIL_LEN = 3.
- Sub-module `siso_step_cnt`: a loadable up/down counter of BLKLEN_W bits with a terminal-count compare.
  - Instantiated three times: write pair count, a-priori count, and read address.

## Test plan
- Reset held for 10 cycles, then released → all outputs 0 and `busy`=0.
- K=512 with 1024 `valid_in` and 512 `valid_apriori` words (no tail):
  - 512 `wr_en` pulses on addresses 0..511.
  - FWD reads 0..511 with `alpha_init` at 0.
  - BWD reads 511..0 with `beta_init` at 511.
  - `done` 1 cycle after the read of 0.
- With `SISO_SCHED_TAIL_EN`, K=40 and 86 words → BWD reads 42, 41, 40, then 39..0 (43 cycles).
- `blklen`=39, then 6145 → a `cfg_err` pulse each time and the block stays in IDLE. A following `blklen`=40 enters LOAD.
- K=40 with 82 `valid_in` words → 2 `ovf_err` pulses; only addresses 0..39 are written.
- Reset asserted mid-FWD at address 100 → next cycle `rd_en`=0 and `busy`=0. A new K=64 block completes normally.
